// File: rtl/jk_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_reg_bank
// Brief    : WIDTH-bit register bank with per-bit JK, up/down count and
//            shift-left modes, terminal count and a registered wrap pulse.
// Revision : 1.0  initial release
// ============================================================================
module jk_reg_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0] c_MODE_JK    = 2'b00;
    localparam logic [1:0] c_MODE_UP    = 2'b01;
    localparam logic [1:0] c_MODE_DOWN  = 2'b10;
    localparam logic [1:0] c_MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc;

    always_comb begin
        w_tc = 1'b0;
        if (mode == c_MODE_UP && r_q == {WIDTH{1'b1}}) begin
            w_tc = 1'b1;
        end else if (mode == c_MODE_DOWN && r_q == '0) begin
            w_tc = 1'b1;
        end
    end

    always_comb begin
        w_q_next = r_q;
        if (en) begin
            case (mode)
                // Classic JK equation: 00 hold, 01 clear, 10 set, 11 toggle.
                c_MODE_JK:    w_q_next = (r_q & ~k) | (~r_q & j);
                c_MODE_UP:    w_q_next = r_q + 1'b1;
                c_MODE_DOWN:  w_q_next = r_q - 1'b1;
                c_MODE_SHIFT: w_q_next = {r_q[WIDTH-2:0], j[0]};
                default:      w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= RESET_VALUE;
            r_wrap <= 1'b0;
        end else if (set) begin
            r_q    <= {WIDTH{1'b1}};
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= en & w_tc;
        end
    end

    assign q    = r_q;
    assign qb   = ~r_q;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_jk_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_reg_bank
// Brief    : Table-driven self-checking bench for jk_reg_bank (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_reg_bank;

    localparam int c_W = 4;

    typedef struct {
        logic           rst;
        logic           st;
        logic           en;
        logic [1:0]     mode;
        logic [c_W-1:0] j;
        logic [c_W-1:0] k;
        logic [c_W-1:0] exp_q;
        logic           exp_tc;
        logic           exp_wrap;
    } vec_t;

    typedef struct {
        logic [c_W-1:0] q;
        logic           tc;
        logic           wrap;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           set = 1'b0;
    logic           en = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [c_W-1:0] j = '0;
    logic [c_W-1:0] k = '0;
    logic [c_W-1:0] q;
    logic [c_W-1:0] qb;
    logic           tc;
    logic           wrap;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t tbl[$];
    exp_t sb[$];

    jk_reg_bank #(.WIDTH(c_W), .RESET_VALUE(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .en    (en),
        .mode  (mode),
        .j     (j),
        .k     (k),
        .q     (q),
        .qb    (qb),
        .tc    (tc),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_compared++;
        if (act !== exp_v) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Drive one edge worth of inputs, queue the expectation, then check after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        reset = v.rst;
        set   = v.st;
        en    = v.en;
        mode  = v.mode;
        j     = v.j;
        k     = v.k;
        e.q    = v.exp_q;
        e.tc   = v.exp_tc;
        e.wrap = v.exp_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("q",    {28'd0, q},    {28'd0, e.q});
            check("qb",   {28'd0, qb},   {28'd0, ~e.q});
            check("tc",   {31'd0, tc},   {31'd0, e.tc});
            check("wrap", {31'd0, wrap}, {31'd0, e.wrap});
        end
    endtask

    initial begin
        vec_t v;

        //                rst  set  en   mode   j        k        q        tc   wrap
        tbl.push_back('{1'b1,1'b0,1'b0,2'b00,4'b0000,4'b0000,4'b0000,1'b0,1'b0});
        // JK mode
        tbl.push_back('{1'b0,1'b0,1'b1,2'b00,4'b1010,4'b0000,4'b1010,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b00,4'b1111,4'b1111,4'b0101,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b00,4'b0000,4'b0100,4'b0001,1'b0,1'b0});
        // JK hold with en low
        tbl.push_back('{1'b0,1'b0,1'b0,2'b00,4'b1111,4'b1111,4'b0001,1'b0,1'b0});
        // Shift mode from zero, serial 1,0,1,1 (k ignored)
        tbl.push_back('{1'b1,1'b0,1'b1,2'b11,4'b0000,4'b0000,4'b0000,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b11,4'b0001,4'b1111,4'b0001,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b11,4'b1110,4'b1010,4'b0010,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b11,4'b0001,4'b0000,4'b0101,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b11,4'b1111,4'b0101,4'b1011,1'b0,1'b0});
        // Count up through wrap
        tbl.push_back('{1'b0,1'b1,1'b0,2'b00,4'b0000,4'b0000,4'b1111,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b10,4'b0000,4'b0000,4'b1110,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b1111,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b0000,1'b0,1'b1});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b0001,1'b0,1'b0});
        // Count down through wrap, then hold at zero with en low
        tbl.push_back('{1'b0,1'b0,1'b1,2'b10,4'b0000,4'b0000,4'b0000,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b10,4'b0000,4'b0000,4'b1111,1'b0,1'b1});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b0000,1'b0,1'b1});
        tbl.push_back('{1'b0,1'b0,1'b0,2'b10,4'b0000,4'b0000,4'b0000,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b0,2'b10,4'b0000,4'b0000,4'b0000,1'b1,1'b0});
        // Set / reset priority
        tbl.push_back('{1'b1,1'b1,1'b1,2'b01,4'b1111,4'b1111,4'b0000,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,2'b01,4'b0000,4'b0000,4'b1111,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,2'b01,4'b0000,4'b0000,4'b1111,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,2'b00,4'b0000,4'b1111,4'b0000,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,2'b00,4'b0000,4'b1111,4'b1111,1'b0,1'b0});

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i]);
        end

        // Reset in the middle of a count, then resume from RESET_VALUE
        v = '{1'b1,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b0000,1'b0,1'b0};
        step(v);
        for (int n = 1; n <= 7; n++) begin
            v = '{1'b0,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'(n),1'b0,1'b0};
            step(v);
        end
        v = '{1'b1,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b0000,1'b0,1'b0};
        step(v);
        v = '{1'b0,1'b0,1'b1,2'b01,4'b0000,4'b0000,4'b0001,1'b0,1'b0};
        step(v);

        // tc follows mode combinationally without an edge
        reset = 1'b0; set = 1'b0; en = 1'b0; mode = 2'b10;
        #1;
        check("tc_mode_down_q1", {31'd0, tc}, 32'd0);
        v = '{1'b0,1'b0,1'b1,2'b10,4'b0000,4'b0000,4'b0000,1'b1,1'b0};
        step(v);
        mode = 2'b01;
        #1;
        check("tc_mode_up_q0", {31'd0, tc}, 32'd0);
        mode = 2'b00;
        #1;
        check("tc_mode_jk_q0", {31'd0, tc}, 32'd0);

        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface

REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, the WIDTH-bit value loaded by reset.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change only on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port set, input, 1: synchronous active-high preset; loads all ones.
REQ-006 Port en, input, 1: operation enable; when low, the state SHALL hold (reset and set still act).
REQ-007 Port mode, input, 2: 00 = JK bitwise, 01 = count up, 10 = count down, 11 = shift left.
REQ-008 Port j, input, WIDTH: per-bit J inputs; j[0] is also the serial input in shift mode.
REQ-009 Port k, input, WIDTH: per-bit K inputs; ignored outside JK mode.
REQ-010 Port q, output, WIDTH: registered state.
REQ-011 Port qb, output, WIDTH: bitwise complement of q at all times.
REQ-012 Port tc, output, 1: combinational terminal count.
REQ-013 Port wrap, output, 1: registered one-cycle wrap pulse.

Function

REQ-014 Per-edge priority SHALL be reset > set > en low (hold) > mode operation.
REQ-015 In JK mode, bit i SHALL take the value: jk=00 hold, 01 clear, 10 set, 11 toggle, independently for each i.
REQ-016 In count-up mode, q SHALL become q+1 modulo 2^WIDTH; from all ones it SHALL become 0.
REQ-017 In count-down mode, q SHALL become q-1 modulo 2^WIDTH; from 0 it SHALL become all ones.
REQ-018 In shift mode, q SHALL become {q[WIDTH-2:0], j[0]}; the MSB is discarded.
REQ-019 tc SHALL be 1 when mode=01 and q is all ones, or when mode=10 and q=0; otherwise tc SHALL be 0, regardless of en.
REQ-020 wrap SHALL be 1 for exactly the cycle after an edge where en=1, tc=1, reset=0 and set=0 (a count wrap occurred); otherwise it SHALL be 0.
REQ-021 If mode changes between edges, the new mode SHALL take effect at the next edge with no added latency.
REQ-022 Latency: every update SHALL appear on q one edge after the inputs are sampled.
REQ-023 When set=1, q SHALL become all ones and wrap SHALL become 0, regardless of en, mode, j and k.
REQ-024 The block SHALL contain no latches and no asynchronous paths from set or reset to q.

Reset

REQ-025 On an edge with reset=1, q SHALL become RESET_VALUE, qb SHALL become ~RESET_VALUE, and wrap SHALL become 0, regardless of all other inputs.
REQ-026 If reset is asserted mid-count or mid-shift, the operation SHALL abort with no residual state; the first edge after reset deasserts SHALL operate on RESET_VALUE.
REQ-027 Before the first reset edge, q is undefined; the bench SHALL apply reset for at least 1 cycle before checking.

Verification (WIDTH=4, RESET_VALUE=0)

REQ-028 JK mode from q=0000 with j=1010, k=0000 -> q=1010; then with j=1111, k=1111 -> q=0101; then with j=0000, k=0100 -> q=0001; qb is always ~q.
REQ-029 Count up from q=1110 with en=1 -> q=1111 with tc=1 -> q=0000 with wrap=1 for one cycle, then wrap=0 at q=0001.
REQ-030 Count down from q=0001 -> q=0000 with tc=1 -> q=1111 with wrap=1; with en=0 at q=0000, q holds, tc=1 and wrap=0.
REQ-031 Shift mode from q=0000 with j[0] sequence 1,0,1,1 -> q=0001, 0010, 0101, 1011.
REQ-032 When set=1 and reset=1 are asserted on the same edge while counting -> q=0000; when set alone is asserted -> q=1111 and wrap=0; when set is asserted with en=0 -> q=1111.
REQ-033 Assert reset mid-count at q=0111 -> q=0000 on that edge; after reset deasserts with mode=01 -> q=0001.
